lfsr_victim_sel: RTL and testbench
==================================

# lfsr_victim_sel

Parametrised LFSR-based victim selector for set-associative caches and arbitration tables; the successor to the fixed 8-bit refill LFSR. It generalises the register width and way count, and adds a request/response handshake. It also adds an eligibility mask, which keeps locked or invalid ways out of the selection, and a bounded-retry fallback to the lowest eligible way. It sits between a cache controller's miss handler and its refill write path.

## Interface
- `LfsrWidth`, default 16: LFSR width; legal range 4..32.
- `NumWays`, default 8: number of selectable ways; 2 ≤ NumWays ≤ 2^LfsrWidth; need not be a power of two.
- `Seed`, default `'h1`: reset and clear value; must be non-zero.
- `MaxRetries`, default 4: maximum number of draws before fallback; must be ≥ 1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clr_i`  in  1  synchronous clear of the LFSR to `Seed`.
- `seed_load_i`  in  1  load `seed_i` into the LFSR.
- `seed_i`  in  LfsrWidth  seed value.
- `en_i`  in  1  free-running LFSR advance.
- `req_valid_i` / `req_ready_o`  in/out  1  selection request handshake.
- `mask_i`  in  NumWays  eligible ways; sampled when a request is accepted.
- `rsp_valid_o` / `rsp_ready_i`  out/in  1  response handshake.
- `rsp_way_oh_o`  out  NumWays  selected way, one-hot.
- `rsp_way_bin_o`  out  $clog2(NumWays)  selected way, binary.
- `rsp_fallback_o`  out  1  set when the way came from fallback, not from the LFSR.
- `lfsr_o`  out  LfsrWidth  current LFSR state.

## Operation
- LFSR is a Fibonacci shift-left register: next = {s[W-2:0], ^(s & Taps[W])}. The taps are maximal-length.
- Update priority: rst_i > clr_i > seed_load_i > step.
  - A seed load of 0 stores `Seed` instead; this prevents lock-up.
  - A step occurs if `en_i` is high or a draw happens in that cycle; at most one step per cycle.
- FSM states:
  - IDLE: `req_ready_o`=1. On accept, capture `mask_i`, clear the retry counter, and go to DRAW. If the captured mask is all zero, go directly to RESP with oh=0, bin=0, fallback=1.
  - DRAW: idx = s[$clog2(NumWays)-1:0] using the current state; the LFSR then steps.
    - Hit (idx < NumWays and mask[idx]=1): register the way, set fallback=0, go to RESP.
    - Miss: increment the counter. Once MaxRetries misses have occurred, register the lowest set mask bit, set fallback=1, and go to RESP.
  - RESP: `rsp_valid_o`=1. All `rsp_*` outputs are held stable until `rsp_ready_i`; then go to IDLE. `req_ready_o`=0.
- `clr_i` and `seed_load_i` affect only the LFSR, never the FSM or a pending response.
- Reset values: LFSR=`Seed`, FSM=IDLE, `req_ready_o`=1, `rsp_valid_o`=0, `rsp_way_oh_o`=0, `rsp_way_bin_o`=0, `rsp_fallback_o`=0.
- Reset mid-operation aborts the transaction; nothing of it remains.

## Timing
- Accept edge = cycle 0. A hit on the n-th draw gives `rsp_valid_o` in cycle n+1 (minimum 2).
- Fallback gives `rsp_valid_o` in cycle MaxRetries+1. An all-zero mask gives `rsp_valid_o` in cycle 1.
- Throughput: one request per (latency + 1) cycles. The earliest re-accept is the cycle after the response handshake.
- `lfsr_o` is registered; changes to `mask_i` after acceptance have no effect.

## Structure
- `lfsr_pkg` holds the maximal-length tap table `Taps[4..32]` (e.g. W=4 → `4'b1001`) and the FSM state enum.
- The lowest-set-bit fallback uses the existing `lzc` module (count trailing zeros mode).
- The LFSR, FSM and the retry counter of width $clog2(MaxRetries+1) are inline.

## Test plan
Common configuration: LfsrWidth=4, NumWays=4, Seed=1, MaxRetries=4, en_i=0.
- mask=1111, request immediately after reset → cycle 2: bin=1, oh=0010, fallback=0; `lfsr_o`=0011.
- mask=1000 → first draw misses (0001), second draw hits (0011) → cycle 3: bin=3, oh=1000; `lfsr_o`=0111.
- mask=0100 → draws 0001, 0011, 0111, 1111 all miss → cycle 5: bin=2, fallback=1; `lfsr_o`=1110.
- mask=0000 → cycle 1: oh=0000, bin=0, fallback=1.
- Seed checks:
  - seed_load_i with seed_i=0 → `lfsr_o`=0001.
  - en_i=1 for 15 cycles → 15 distinct non-zero states, then 0001 again.
- rsp_ready_i held low for 3 cycles → outputs stable and `req_ready_o`=0. rst_i pulsed during DRAW → next cycle IDLE, `rsp_valid_o`=0, `lfsr_o`=0001.

Source files
------------

// File: rtl/lfsr_victim_sel_pkg.sv
// Shared types and the maximal-length tap table for the LFSR victim selector.
package lfsr_victim_sel_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDraw = 2'd1,
        StResp = 2'd2
    } state_e;

    // Bit (w-1) is the constant term; each extra polynomial exponent t lands on bit (w-1-t).
    function automatic logic [31:0] tap_mask(input int unsigned w, input int unsigned a,
                                             input int unsigned b, input int unsigned c);
        logic [31:0] m;
        m = '0;
        m[5'(w - 1)] = 1'b1;
        if (a != 0) m[5'(w - 1 - a)] = 1'b1;
        if (b != 0) m[5'(w - 1 - b)] = 1'b1;
        if (c != 0) m[5'(w - 1 - c)] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        case (w)
            4:       return tap_mask(w, 3, 0, 0);
            5:       return tap_mask(w, 3, 0, 0);
            6:       return tap_mask(w, 5, 0, 0);
            7:       return tap_mask(w, 6, 0, 0);
            8:       return tap_mask(w, 6, 5, 4);
            9:       return tap_mask(w, 5, 0, 0);
            10:      return tap_mask(w, 7, 0, 0);
            11:      return tap_mask(w, 9, 0, 0);
            12:      return tap_mask(w, 6, 4, 1);
            13:      return tap_mask(w, 4, 3, 1);
            14:      return tap_mask(w, 5, 3, 1);
            15:      return tap_mask(w, 14, 0, 0);
            16:      return tap_mask(w, 15, 13, 4);
            17:      return tap_mask(w, 14, 0, 0);
            18:      return tap_mask(w, 11, 0, 0);
            19:      return tap_mask(w, 6, 2, 1);
            20:      return tap_mask(w, 17, 0, 0);
            21:      return tap_mask(w, 19, 0, 0);
            22:      return tap_mask(w, 21, 0, 0);
            23:      return tap_mask(w, 18, 0, 0);
            24:      return tap_mask(w, 23, 22, 17);
            25:      return tap_mask(w, 22, 0, 0);
            26:      return tap_mask(w, 6, 2, 1);
            27:      return tap_mask(w, 5, 2, 1);
            28:      return tap_mask(w, 25, 0, 0);
            29:      return tap_mask(w, 27, 0, 0);
            30:      return tap_mask(w, 6, 4, 1);
            31:      return tap_mask(w, 28, 0, 0);
            32:      return tap_mask(w, 22, 2, 1);
            default: return 32'h0000_0009;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_victim_sel_if.sv
// Request/response handshake between a miss handler (master) and the victim selector (slave).
interface lfsr_victim_sel_if #(
    parameter int unsigned NumWays = 8
) ();
    localparam int unsigned WayW = $clog2(NumWays);

    logic                req_valid;
    logic                req_ready;
    logic [NumWays-1:0]  mask;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [NumWays-1:0]  rsp_way_oh;
    logic [WayW-1:0]     rsp_way_bin;
    logic                rsp_fallback;

    modport master (
        output req_valid, mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_way_oh, rsp_way_bin, rsp_fallback
    );

    modport slave (
        input  req_valid, mask, rsp_ready,
        output req_ready, rsp_valid, rsp_way_oh, rsp_way_bin, rsp_fallback
    );
endinterface

// File: rtl/lfsr_victim_sel_lzc.sv
// Zero counter: Mode=1 counts trailing zeros (index of lowest set bit), Mode=0 leading zeros.
module lfsr_victim_sel_lzc #(
    parameter int unsigned Width = 8,
    parameter bit          Mode  = 1'b1
) (
    input  logic [Width-1:0]         data,
    output logic [$clog2(Width)-1:0] cnt_c
);
    localparam int unsigned CntW = $clog2(Width);

    // All-zero input yields zero; callers guard that case themselves.
    always_comb begin
        cnt_c = '0;
        if (Mode) begin
            for (int i = Width - 1; i >= 0; i--) begin
                if (data[i]) cnt_c = CntW'(i);
            end
        end else begin
            for (int i = 0; i < Width; i++) begin
                if (data[i]) cnt_c = CntW'(Width - 1 - i);
            end
        end
    end
endmodule

// File: rtl/lfsr_victim_sel.sv
// LFSR-based victim way selector with eligibility mask and bounded-retry fallback
// to the lowest eligible way.
module lfsr_victim_sel
    import lfsr_victim_sel_pkg::*;
#(
    parameter int unsigned          LfsrWidth  = 16,
    parameter int unsigned          NumWays    = 8,
    parameter logic [LfsrWidth-1:0] Seed       = 'h1,
    parameter int unsigned          MaxRetries = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 seed_load_i,
    input  logic [LfsrWidth-1:0] seed_i,
    input  logic                 en_i,
    lfsr_victim_sel_if.slave     bus,
    output logic [LfsrWidth-1:0] lfsr_o
);
    localparam int unsigned          WayW = $clog2(NumWays);
    localparam int unsigned          CntW = $clog2(MaxRetries + 1);
    localparam logic [LfsrWidth-1:0] Taps = LfsrWidth'(lfsr_taps(LfsrWidth));

    state_e               state_q, state_d;
    logic [LfsrWidth-1:0] lfsr_q, lfsr_step;
    logic [NumWays-1:0]   mask_q, mask_d;
    logic [NumWays-1:0]   oh_q, oh_d;
    logic [WayW-1:0]      bin_q, bin_d;
    logic [WayW-1:0]      idx, low_idx;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 fb_q, fb_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 draw, hit;

    assign lfsr_step = {lfsr_q[LfsrWidth-2:0], ^(lfsr_q & Taps)};
    assign idx       = lfsr_q[WayW-1:0];
    // Draws that land beyond NumWays (non power-of-two way counts) count as misses.
    assign hit       = ({1'b0, idx} < (WayW + 1)'(NumWays)) && mask_q[idx];

    lfsr_victim_sel_lzc #(
        .Width (NumWays),
        .Mode  (1'b1)
    ) u_lzc (
        .data  (mask_q),
        .cnt_c (low_idx)
    );

    // LFSR: a draw and en_i together still advance only one step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= Seed;
        end else if (clr_i) begin
            lfsr_q <= Seed;
        end else if (seed_load_i) begin
            lfsr_q <= (seed_i == '0) ? Seed : seed_i;
        end else if (en_i || draw) begin
            lfsr_q <= lfsr_step;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            cnt_q       <= '0;
            oh_q        <= '0;
            bin_q       <= '0;
            fb_q        <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            oh_q        <= oh_d;
            bin_q       <= bin_d;
            fb_q        <= fb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        oh_d    = oh_q;
        bin_d   = bin_q;
        fb_d    = fb_q;
        draw    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    mask_d = bus.mask;
                    cnt_d  = '0;
                    if (bus.mask == '0) begin
                        oh_d    = '0;
                        bin_d   = '0;
                        fb_d    = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StDraw;
                    end
                end
            end
            StDraw: begin
                draw = 1'b1;
                if (hit) begin
                    oh_d    = NumWays'(1) << idx;
                    bin_d   = idx;
                    fb_d    = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(MaxRetries - 1)) begin
                        oh_d    = NumWays'(1) << low_idx;
                        bin_d   = low_idx;
                        fb_d    = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        req_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_way_oh   = oh_q;
    assign bus.rsp_way_bin  = bin_q;
    assign bus.rsp_fallback = fb_q;
    assign lfsr_o           = lfsr_q;

endmodule

// File: tb/tb_lfsr_victim_sel.sv
// Self-checking bench for lfsr_victim_sel (W=4, 4 ways, Seed=1, MaxRetries=4).
module tb_lfsr_victim_sel;
    localparam int unsigned W  = 4;
    localparam int unsigned N  = 4;
    localparam int unsigned MR = 4;

    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] oh;
        logic [1:0]   bin;
        logic         fb;
        int           lat;
        logic [W-1:0] lfsr;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, clr, seed_load, en;
    logic [W-1:0] seed;
    logic [W-1:0] lfsr;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    lfsr_victim_sel_if #(.NumWays(N)) bus ();

    lfsr_victim_sel #(
        .LfsrWidth  (W),
        .NumWays    (N),
        .Seed       (4'h1),
        .MaxRetries (MR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .seed_load_i (seed_load),
        .seed_i      (seed),
        .en_i        (en),
        .bus         (bus),
        .lfsr_o      (lfsr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Issue one request, hold the response for 'hold' extra cycles, then complete the handshake.
    task automatic run_req(input vec_t v, input int hold, input string tag);
        vec_t e;
        int   lat;
        sb.push_back(v);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.mask      = v.mask;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        bus.mask      = ~v.mask;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        if (!bus.rsp_valid) return;
        check({tag, ".latency"},  32'(lat),              32'(e.lat));
        check({tag, ".oh"},       32'(bus.rsp_way_oh),   32'(e.oh));
        check({tag, ".bin"},      32'(bus.rsp_way_bin),  32'(e.bin));
        check({tag, ".fallback"}, 32'(bus.rsp_fallback), 32'(e.fb));
        check({tag, ".lfsr"},     32'(lfsr),             32'(e.lfsr));
        check({tag, ".busy"},     32'(bus.req_ready),    32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, ".hold_valid"}, 32'(bus.rsp_valid),    32'd1);
            check({tag, ".hold_oh"},    32'(bus.rsp_way_oh),   32'(e.oh));
            check({tag, ".hold_bin"},   32'(bus.rsp_way_bin),  32'(e.bin));
            check({tag, ".hold_fb"},    32'(bus.rsp_fallback), 32'(e.fb));
            check({tag, ".hold_busy"},  32'(bus.req_ready),    32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check({tag, ".done_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".done_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] seen;
        vec_t        v;

        //          mask     oh       bin   fb    lat lfsr
        vecs[0] = '{4'b1111, 4'b0010, 2'd1, 1'b0, 2, 4'b0011};
        vecs[1] = '{4'b1000, 4'b1000, 2'd3, 1'b0, 3, 4'b0111};
        vecs[2] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 5, 4'b1110};
        vecs[3] = '{4'b0000, 4'b0000, 2'd0, 1'b1, 1, 4'b0001};
        vecs[4] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 5, 4'b1110};
        vecs[5] = '{4'b0110, 4'b0010, 2'd1, 1'b0, 2, 4'b0011};
        vecs[6] = '{4'b1001, 4'b1000, 2'd3, 1'b0, 3, 4'b0111};

        rst = 1'b1; clr = 1'b0; seed_load = 1'b0; seed = '0; en = 1'b0;
        bus.req_valid = 1'b0; bus.mask = '0; bus.rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("reset.req_ready", 32'(bus.req_ready),    32'd1);
        check("reset.rsp_valid", 32'(bus.rsp_valid),    32'd0);
        check("reset.oh",        32'(bus.rsp_way_oh),   32'd0);
        check("reset.bin",       32'(bus.rsp_way_bin),  32'd0);
        check("reset.fallback",  32'(bus.rsp_fallback), 32'd0);
        check("reset.lfsr",      32'(lfsr),             32'h1);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_req(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Back-to-back: LFSR continues; the last sequence hits exactly on the final allowed draw.
        do_reset();
        run_req(vecs[0], 0, "b2b0");
        v = '{4'b1111, 4'b1000, 2'd3, 1'b0, 2, 4'b0111};
        run_req(v, 0, "b2b1");
        v = '{4'b0010, 4'b0010, 2'd1, 1'b0, 5, 4'b1010};
        run_req(v, 0, "b2b_lastdraw");

        // Response held while rsp_ready stays low.
        do_reset();
        run_req(vecs[0], 3, "hold");

        // Seed load, zero-seed substitution, clear priority over load.
        seed_load = 1'b1; seed = 4'hA;
        tick();
        check("seed.load", 32'(lfsr), 32'hA);
        seed = 4'h0;
        tick();
        check("seed.zero", 32'(lfsr), 32'h1);
        seed = 4'h6; clr = 1'b1;
        tick();
        check("seed.clr_prio", 32'(lfsr), 32'h1);
        clr = 1'b0; seed_load = 1'b0;

        // Free-running period: 15 distinct non-zero states, then back to the seed.
        do_reset();
        en = 1'b1;
        seen = 16'h0002;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 1) check("period.first", 32'(lfsr), 32'h3);
            if (i < 15) begin
                check("period.nonzero", 32'(lfsr != '0), 32'd1);
                check("period.distinct", 32'(seen[lfsr]), 32'd0);
                seen[lfsr] = 1'b1;
            end else begin
                check("period.wrap", 32'(lfsr), 32'h1);
            end
        end
        tick();
        clr = 1'b1;
        en  = 1'b0;
        tick();
        clr = 1'b0;
        check("clr.lfsr", 32'(lfsr), 32'h1);

        // Reset in the middle of DRAW abandons the transaction.
        do_reset();
        bus.mask = 4'b0100; bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("abort.busy",  32'(bus.req_ready), 32'd0);
        check("abort.valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.req_ready", 32'(bus.req_ready), 32'd1);
        check("abort.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort.lfsr",      32'(lfsr),          32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort.quiet", 32'(bus.rsp_valid), 32'd0);
        end
        run_req(vecs[0], 0, "abort.fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
